id_stage: RTL and testbench

Instruction-decode stage of the five-stage pipeline, sitting between the IF/ID register and the EX stage. It drives the register-file read addresses and decodes the instruction into operands, immediate and control fields. It bypasses the same-cycle writeback, interlocks on read-after-write hazards against EX and MEM, and holds the ID/EX pipeline register with a valid/ready handshake.

---
 rtl/rv32i_pkg.sv | 39 +++
 rtl/id_stage_imm_gen.sv | 33 +++
 rtl/id_stage.sv | 174 +++++++++++++++++
 tb/tb_id_stage.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I decode definitions (opcodes, datapath width, immediate formats).
// Latency: n/a (types, constants and a pure decode helper only).
// Backpressure: n/a.
package rv32i_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

  // Immediate format selected purely by the major opcode.
  function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opc);
    case (opc)
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: return FMT_I;
      OPC_STORE:                      return FMT_S;
      OPC_BRANCH:                     return FMT_B;
      OPC_LUI, OPC_AUIPC:             return FMT_U;
      OPC_JAL:                        return FMT_J;
      default:                        return FMT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_imm_gen.sv
// imm_gen: extracts the sign-extended immediate of an RV32I instruction.
// Latency: combinational. Backpressure: none (pure function of inst).
// Ports: i_inst (32b instruction word) -> o_imm (XLEN-bit immediate, 0 for formats without one).
module imm_gen
  import rv32i_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [31:0]     i_inst,
  output logic [XLEN-1:0] o_imm
);

  imm_fmt_e w_fmt;

  assign w_fmt = imm_fmt_of(i_inst[6:0]);

  // inst[31] is the sign bit in every format, so each case replicates it
  // directly out to XLEN.
  always_comb begin
    o_imm = '0;
    case (w_fmt)
      FMT_I: o_imm = {{(XLEN-11){i_inst[31]}}, i_inst[30:20]};
      FMT_S: o_imm = {{(XLEN-11){i_inst[31]}}, i_inst[30:25], i_inst[11:7]};
      FMT_B: o_imm = {{(XLEN-12){i_inst[31]}}, i_inst[7], i_inst[30:25],
                      i_inst[11:8], 1'b0};
      FMT_U: o_imm = {{(XLEN-31){i_inst[31]}}, i_inst[30:12], 12'b0};
      FMT_J: o_imm = {{(XLEN-20){i_inst[31]}}, i_inst[19:12], i_inst[20],
                      i_inst[30:21], 1'b0};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I decode stage; regfile addressing, WB bypass, RAW interlock, ID/EX register.
// Latency: 1 cycle from acceptance (if_valid & id_ready) to ex_valid.
// Backpressure: holds ID/EX while ex_valid & ~ex_ready; id_ready drops on that or on a RAW hazard.
// Ports: IF side (if_valid/if_pc/if_inst/id_ready), regfile read (rs*_addr/rs*_data),
//        WB write port and MEM destination for bypass/hazard, flush, EX side (ex_ready/ex_*).
module id_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_inst,
  output logic            id_ready,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            wb_w_en,
  input  logic [4:0]      wb_rd_addr,
  input  logic [XLEN-1:0] wb_w_data,
  input  logic            mem_reg_write,
  input  logic [4:0]      mem_rd_addr,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd_addr,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7_b5,
  output logic            ex_reg_write
);

  logic [6:0]      w_opcode;
  logic [4:0]      w_rd;
  logic            w_rs1_used;
  logic            w_rs2_used;
  logic            w_writes_rd;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic            w_rs1_haz;
  logic            w_rs2_haz;
  logic            w_hazard;
  logic            w_stall_out;

  logic            r_ex_valid;
  logic [XLEN-1:0] r_ex_pc;
  logic [XLEN-1:0] r_ex_rs1_data;
  logic [XLEN-1:0] r_ex_rs2_data;
  logic [XLEN-1:0] r_ex_imm;
  logic [4:0]      r_ex_rd_addr;
  logic [6:0]      r_ex_opcode;
  logic [2:0]      r_ex_funct3;
  logic            r_ex_funct7_b5;
  logic            r_ex_reg_write;

  assign w_opcode = if_inst[6:0];
  assign w_rd     = if_inst[11:7];
  assign rs1_addr = if_inst[19:15];
  assign rs2_addr = if_inst[24:20];

  // Register usage per opcode; unknown opcodes read nothing and write nothing.
  always_comb begin
    w_rs1_used  = 1'b0;
    w_rs2_used  = 1'b0;
    w_writes_rd = 1'b0;
    case (w_opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: w_writes_rd = 1'b1;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
        w_rs1_used  = 1'b1;
        w_writes_rd = 1'b1;
      end
      OPC_BRANCH, OPC_STORE: begin
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
      end
      OPC_OP: begin
        w_rs1_used  = 1'b1;
        w_rs2_used  = 1'b1;
        w_writes_rd = 1'b1;
      end
      default: ;
    endcase
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_inst (if_inst),
    .o_imm  (w_imm)
  );

  // The regfile does not write through, so the same-cycle WB value is
  // muxed in here. x0 is forced to zero regardless of what the array returns.
  always_comb begin
    if (rs1_addr == 5'd0)
      w_rs1_val = '0;
    else if (wb_w_en && (wb_rd_addr == rs1_addr))
      w_rs1_val = wb_w_data;
    else
      w_rs1_val = rs1_data;

    if (rs2_addr == 5'd0)
      w_rs2_val = '0;
    else if (wb_w_en && (wb_rd_addr == rs2_addr))
      w_rs2_val = wb_w_data;
    else
      w_rs2_val = rs2_data;
  end

  // No EX/MEM forwarding: any in-flight producer of a used source interlocks.
  // r_ex_reg_write is already cleared for rd = x0, and rsN != 0 excludes x0.
  assign w_rs1_haz = w_rs1_used && (rs1_addr != 5'd0) &&
                     ((r_ex_valid && r_ex_reg_write && (r_ex_rd_addr == rs1_addr)) ||
                      (mem_reg_write && (mem_rd_addr == rs1_addr)));
  assign w_rs2_haz = w_rs2_used && (rs2_addr != 5'd0) &&
                     ((r_ex_valid && r_ex_reg_write && (r_ex_rd_addr == rs2_addr)) ||
                      (mem_reg_write && (mem_rd_addr == rs2_addr)));

  assign w_hazard    = if_valid && (w_rs1_haz || w_rs2_haz);
  assign w_stall_out = r_ex_valid && !ex_ready;
  assign id_ready    = !w_stall_out && !w_hazard;

  // ID/EX register. Flush beats stall; on a flush or bubble only the valid
  // bit changes, the payload is left as-is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid     <= 1'b0;
      r_ex_pc        <= '0;
      r_ex_rs1_data  <= '0;
      r_ex_rs2_data  <= '0;
      r_ex_imm       <= '0;
      r_ex_rd_addr   <= '0;
      r_ex_opcode    <= '0;
      r_ex_funct3    <= '0;
      r_ex_funct7_b5 <= 1'b0;
      r_ex_reg_write <= 1'b0;
    end else if (flush) begin
      r_ex_valid <= 1'b0;
    end else if (!w_stall_out) begin
      if (w_hazard) begin
        r_ex_valid <= 1'b0;
      end else begin
        r_ex_valid     <= if_valid;
        r_ex_pc        <= if_pc;
        r_ex_rs1_data  <= w_rs1_val;
        r_ex_rs2_data  <= w_rs2_val;
        r_ex_imm       <= w_imm;
        r_ex_rd_addr   <= w_rd;
        r_ex_opcode    <= w_opcode;
        r_ex_funct3    <= if_inst[14:12];
        r_ex_funct7_b5 <= if_inst[30];
        r_ex_reg_write <= w_writes_rd && (w_rd != 5'd0);
      end
    end
  end

  assign ex_valid     = r_ex_valid;
  assign ex_pc        = r_ex_pc;
  assign ex_rs1_data  = r_ex_rs1_data;
  assign ex_rs2_data  = r_ex_rs2_data;
  assign ex_imm       = r_ex_imm;
  assign ex_rd_addr   = r_ex_rd_addr;
  assign ex_opcode    = r_ex_opcode;
  assign ex_funct3    = r_ex_funct3;
  assign ex_funct7_b5 = r_ex_funct7_b5;
  assign ex_reg_write = r_ex_reg_write;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed self-checking bench for id_stage.
// Latency: n/a. Backpressure: drives ex_ready/flush directly.
module tb_id_stage;

  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] ST   = 7'b0100011;
  localparam logic [6:0] OPI  = 7'b0010011;
  localparam logic [6:0] OPR  = 7'b0110011;

  logic        clk;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wb_w_en;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_w_data;
  logic        mem_reg_write;
  logic [4:0]  mem_rd_addr;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rd_addr;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic        ex_funct7_b5;
  logic        ex_reg_write;

  logic [31:0] rf [32];
  int          n_tests;
  int          n_fail;

  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  id_stage #(.XLEN(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .id_ready      (id_ready),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .wb_w_en       (wb_w_en),
    .wb_rd_addr    (wb_rd_addr),
    .wb_w_data     (wb_w_data),
    .mem_reg_write (mem_reg_write),
    .mem_rd_addr   (mem_rd_addr),
    .flush         (flush),
    .ex_ready      (ex_ready),
    .ex_valid      (ex_valid),
    .ex_pc         (ex_pc),
    .ex_rs1_data   (ex_rs1_data),
    .ex_rs2_data   (ex_rs2_data),
    .ex_imm        (ex_imm),
    .ex_rd_addr    (ex_rd_addr),
    .ex_opcode     (ex_opcode),
    .ex_funct3     (ex_funct3),
    .ex_funct7_b5  (ex_funct7_b5),
    .ex_reg_write  (ex_reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Instruction encoders.
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], ST};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], BR};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, LUI};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, JAL};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPR};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
    if_inst  = inst;
    if_pc    = pc;
    if_valid = 1'b1;
    #1;
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    if_valid      = 1'b0;
    if_pc         = '0;
    if_inst       = '0;
    wb_w_en       = 1'b0;
    wb_rd_addr    = '0;
    wb_w_data     = '0;
    mem_reg_write = 1'b0;
    mem_rd_addr   = '0;
    flush         = 1'b0;
    ex_ready      = 1'b1;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[0] = 32'hDEAD_BEEF;   // junk in the array: x0 must still read as 0
    rf[5] = 32'h0000_0011;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ex_valid", {31'b0, ex_valid}, 32'h0);
    check("rst_ex_pc", ex_pc, 32'h0);
    check("rst_ex_imm", ex_imm, 32'h0);
    check("rst_ex_rd", {27'b0, ex_rd_addr}, 32'h0);
    check("rst_ex_reg_write", {31'b0, ex_reg_write}, 32'h0);
    rst_n = 1'b1;

    // Immediates
    drive(enc_i(12'hFFF, 5'd2, 3'b000, 5'd1, OPI), 32'h100);
    check("addi_rdy", {31'b0, id_ready}, 32'h1);
    check("addi_rs1_addr", {27'b0, rs1_addr}, 32'd2);
    step();
    check("addi_valid", {31'b0, ex_valid}, 32'h1);
    check("addi_imm", ex_imm, 32'hFFFF_FFFF);
    check("addi_pc", ex_pc, 32'h100);
    check("addi_rd", {27'b0, ex_rd_addr}, 32'd1);
    check("addi_wr", {31'b0, ex_reg_write}, 32'h1);
    check("addi_opc", {25'b0, ex_opcode}, 32'h13);

    drive(enc_s(12'hFFC, 5'd3, 5'd2, 3'b010), 32'h104);
    check("sw_rs2_addr", {27'b0, rs2_addr}, 32'd3);
    step();
    check("sw_imm", ex_imm, 32'hFFFF_FFFC);
    check("sw_wr", {31'b0, ex_reg_write}, 32'h0);
    check("sw_f3", {29'b0, ex_funct3}, 32'd2);

    drive(enc_b(13'h1FF8, 5'd0, 5'd0, 3'b000), 32'h108);
    step();
    check("beq_imm", ex_imm, 32'hFFFF_FFF8);

    drive(enc_u(20'h12345, 5'd5), 32'h10C);
    step();
    check("lui_imm", ex_imm, 32'h1234_5000);
    check("lui_wr", {31'b0, ex_reg_write}, 32'h1);

    drive(enc_j(21'h000800, 5'd0), 32'h110);
    step();
    check("jal_imm", ex_imm, 32'h0000_0800);
    check("jal_x0_wr", {31'b0, ex_reg_write}, 32'h0);

    // WB bypass
    wb_w_en    = 1'b1;
    wb_rd_addr = 5'd5;
    wb_w_data  = 32'h22;
    drive(enc_r(7'h00, 5'd0, 5'd5, 3'b000, 5'd6), 32'h114);
    check("byp_rdy", {31'b0, id_ready}, 32'h1);
    step();
    check("byp_rs1", ex_rs1_data, 32'h22);
    check("byp_rs2_x0", ex_rs2_data, 32'h0);

    wb_rd_addr = 5'd0;
    wb_w_data  = 32'hFF;
    drive(enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd7), 32'h118);
    step();
    check("x0_wb_rs1", ex_rs1_data, 32'h0);
    check("x0_wb_rs2", ex_rs2_data, 32'h0);

    wb_rd_addr = 5'd9;
    wb_w_data  = 32'h99;
    drive(enc_r(7'h20, 5'd5, 5'd5, 3'b000, 5'd8), 32'h11C);
    step();
    check("nobyp_rs1", ex_rs1_data, 32'h11);
    check("nobyp_rs2", ex_rs2_data, 32'h11);
    check("sub_f7b5", {31'b0, ex_funct7_b5}, 32'h1);
    wb_w_en = 1'b0;

    // Interlock: producer walks EX -> MEM -> WB
    drive(enc_i(12'd7, 5'd0, 3'b000, 5'd1, OPI), 32'h200);
    step();
    check("prod_valid", {31'b0, ex_valid}, 32'h1);
    drive(enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd2), 32'h204);
    check("haz_ex_rdy", {31'b0, id_ready}, 32'h0);
    step();
    check("bubble1", {31'b0, ex_valid}, 32'h0);
    mem_reg_write = 1'b1;
    mem_rd_addr   = 5'd1;
    #1;
    check("haz_mem_rdy", {31'b0, id_ready}, 32'h0);
    step();
    check("bubble2", {31'b0, ex_valid}, 32'h0);
    mem_reg_write = 1'b0;
    wb_w_en       = 1'b1;
    wb_rd_addr    = 5'd1;
    wb_w_data     = 32'd7;
    #1;
    check("haz_wb_rdy", {31'b0, id_ready}, 32'h1);
    step();
    check("cons_valid", {31'b0, ex_valid}, 32'h1);
    check("cons_pc", ex_pc, 32'h204);
    check("cons_rs1", ex_rs1_data, 32'd7);
    check("cons_rs2", ex_rs2_data, 32'd7);
    wb_w_en = 1'b0;

    // Backpressure, then flush while stalled
    ex_ready = 1'b0;
    drive(enc_i(12'd5, 5'd0, 3'b000, 5'd3, OPI), 32'h208);
    for (int i = 0; i < 3; i++) begin
      check("bp_rdy", {31'b0, id_ready}, 32'h0);
      step();
      check("bp_valid", {31'b0, ex_valid}, 32'h1);
      check("bp_pc", ex_pc, 32'h204);
      check("bp_rs1", ex_rs1_data, 32'd7);
    end
    flush = 1'b1;
    #1;
    check("flush_rdy", {31'b0, id_ready}, 32'h0);
    step();
    check("flush_valid", {31'b0, ex_valid}, 32'h0);
    flush    = 1'b0;
    ex_ready = 1'b1;
    #1;
    check("post_flush_rdy", {31'b0, id_ready}, 32'h1);
    step();
    check("post_flush_valid", {31'b0, ex_valid}, 32'h1);
    check("post_flush_pc", ex_pc, 32'h208);
    check("post_flush_imm", ex_imm, 32'd5);

    // No false hazards
    drive(enc_u(20'h00001, 5'd1), 32'h300);
    step();
    drive(enc_j(21'h000008, 5'd0), 32'h304);
    check("jal_nohaz_rdy", {31'b0, id_ready}, 32'h1);
    step();
    mem_reg_write = 1'b1;
    mem_rd_addr   = 5'd1;
    drive(enc_u(20'h00002, 5'd1), 32'h308);
    check("lui_nohaz_rdy", {31'b0, id_ready}, 32'h1);
    step();
    check("lui2_imm", ex_imm, 32'h0000_2000);
    // rs1 field of this LUI encodes x1, which is live in EX and MEM
    drive(enc_u(20'h00008, 5'd3), 32'h30C);
    check("lui_field_rs1", {27'b0, rs1_addr}, 32'd1);
    check("lui_field_rdy", {31'b0, id_ready}, 32'h1);
    step();
    check("lui3_valid", {31'b0, ex_valid}, 32'h1);
    check("lui3_imm", ex_imm, 32'h0000_8000);
    mem_reg_write = 1'b0;

    // Asynchronous reset mid-stream
    drive(enc_i(12'd9, 5'd0, 3'b000, 5'd4, OPI), 32'h400);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'b0, ex_valid}, 32'h0);
    check("arst_pc", ex_pc, 32'h0);
    check("arst_imm", ex_imm, 32'h0);
    check("arst_rd", {27'b0, ex_rd_addr}, 32'h0);
    check("arst_wr", {31'b0, ex_reg_write}, 32'h0);
    step();
    rst_n = 1'b1;
    #1;
    check("rel_valid", {31'b0, ex_valid}, 32'h0);
    step();
    check("rel_first_valid", {31'b0, ex_valid}, 32'h1);
    check("rel_first_pc", ex_pc, 32'h400);
    check("rel_first_imm", ex_imm, 32'd9);

    if_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
